// File: rtl/delay_timer.sv
// delay_timer: prescaled programmable down-counter that paces control_fsm waits
// Ports: clk, reset_n (async, active low); start_delay_counter loads delay_value
// and restarts; enable_delay_counter gates counting; delay_done (DONE), busy
// (COUNTING) and ticks_remaining (current count) are all registered.
module delay_timer #(
  parameter int TICK_CYCLES = 50000,
  parameter int DELAY_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_delay_counter,
  input  logic                   enable_delay_counter,
  input  logic [DELAY_WIDTH-1:0] delay_value,
  output logic                   delay_done,
  output logic                   busy,
  output logic [DELAY_WIDTH-1:0] ticks_remaining
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, COUNTING, DONE} state_t;
  state_t                 state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [DELAY_WIDTH-1:0] count_q, count_d;
  logic                   done_q, done_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    if (start_delay_counter) begin
      count_d = delay_value;
      presc_d = '0;
      state_d = (delay_value != '0) ? COUNTING : DONE;
    end else if (state_q == COUNTING && enable_delay_counter) begin
      if (presc_q == PW'(TICK_CYCLES - 1)) begin
        presc_d = '0;
        count_d = count_q - DELAY_WIDTH'(1);
        if (count_q == DELAY_WIDTH'(1)) state_d = DONE;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    // outputs decoded from next state so they are flops, not decodes of flops
    done_d = (state_d == DONE);
    busy_d = (state_d == COUNTING);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  assign delay_done      = done_q;
  assign busy            = busy_q;
  assign ticks_remaining = count_q;
endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: directed bench with an enabled-edge-count model of delay_timer
module tb_delay_timer;
  localparam int T = 4, W = 8;
  logic clk = 0, reset_n = 1, start = 0, en = 0;
  logic [W-1:0] dv = '0;
  logic done, busy;
  logic [W-1:0] ticks;
  int n_checks = 0, n_pass = 0;
  bit live = 0;
  int m_state = 0, m_n = 0, m_en = 0;
  always #5 clk = ~clk;
  delay_timer #(.TICK_CYCLES(T), .DELAY_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start_delay_counter(start),
    .enable_delay_counter(en), .delay_value(dv),
    .delay_done(done), .busy(busy), .ticks_remaining(ticks)
  );
  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // model: 0 idle, 1 running, 2 done; progress is the number of enabled edges since start
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_n = 0; m_en = 0;
    end else if (start) begin
      m_n = int'(dv); m_en = 0; m_state = (dv != 0) ? 1 : 2;
    end else if (m_state == 1 && en) begin
      m_en++;
      if (m_en == m_n * T) m_state = 2;
    end
  end
  always @(negedge clk) if (live) begin
    check("model_done", int'(done), int'(m_state == 2));
    check("model_busy", int'(busy), int'(m_state == 1));
    check("model_ticks", int'(ticks), (m_state == 1) ? m_n - m_en / T : 0);
  end
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic kick(int n, bit e);
    start = 1; dv = W'(n); en = e;
    step(1);
    start = 0;
  endtask
  initial begin
    #2 reset_n = 0;
    #10 reset_n = 1;
    live = 1;
    en = 1;
    step(3);
    check("idle_done", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    kick(5, 0);
    en = 1;
    step(7);
    check("pre_rst_ticks", int'(ticks), 4);
    reset_n = 0;
    #1;
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ticks", int'(ticks), 0);
    #2 reset_n = 1;
    step(3);
    check("post_rst_done", int'(done), 0);
    check("post_rst_busy", int'(busy), 0);
    en = 0;
    kick(3, 0);
    check("basic_t3", int'(ticks), 3);
    check("basic_busy", int'(busy), 1);
    en = 1;
    step(4);
    check("basic_t2", int'(ticks), 2);
    step(4);
    check("basic_t1", int'(ticks), 1);
    step(3);
    check("basic_e11_done", int'(done), 0);
    check("basic_e11_busy", int'(busy), 1);
    step(1);
    check("basic_e12_done", int'(done), 1);
    check("basic_e12_busy", int'(busy), 0);
    check("basic_e12_ticks", int'(ticks), 0);
    step(20);
    check("basic_hold", int'(done), 1);
    kick(2, 0);
    check("pause_clear", int'(done), 0);
    en = 1;
    step(3);
    en = 0;
    step(5);
    check("pause_ticks", int'(ticks), 2);
    en = 1;
    step(4);
    check("pause_e12", int'(done), 0);
    step(1);
    check("pause_e13", int'(done), 1);
    kick(4, 0);
    en = 1;
    step(6);
    kick(1, 1);
    check("restart_ticks", int'(ticks), 1);
    check("restart_busy", int'(busy), 1);
    step(3);
    check("restart_e3", int'(done), 0);
    step(1);
    check("restart_e4", int'(done), 1);
    kick(0, 1);
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    check("zero_ticks", int'(ticks), 0);
    for (int i = 0; i < 4; i++) begin
      kick(2, 1);
      check("movr_drop", int'(done), 0);
      step(7);
      check("movr_e7", int'(done), 0);
      step(1);
      check("movr_e8", int'(done), 1);
    end
    kick(3, 1);
    check("se_ticks", int'(ticks), 3);
    check("se_busy", int'(busy), 1);
    step(11);
    check("se_e11", int'(done), 0);
    step(1);
    check("se_e12", int'(done), 1);
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
